serial_addsub: RTL and testbench
================================

Name: serial_addsub

Overview:
- Parametrised, multi-cycle two's-complement add/subtract unit for the datapath ALU.
- Generalises the 8-bit conditional complementer: either operand can be inverted, carry-in is injected, and the sum is computed DIGIT bits per cycle.
- Operands are taken in through a valid/ready start handshake. The result and flags are held through a valid/ready result handshake.

Parameters:
- WIDTH, 8, operand/result width in bits; must be a multiple of DIGIT.
- DIGIT, 2, bits summed per cycle; N = WIDTH/DIGIT cycles per operation (DIGIT = WIDTH gives 1-cycle latency).

Ports:
- clk  in  1  Single clock; all state updates on the rising edge.
- rst  in  1  Synchronous, active-high reset.
- start_valid  in  1  Request valid; qualifies a, b, op.
- start_ready  out  1  High only in IDLE.
- a  in  WIDTH  Operand A.
- b  in  WIDTH  Operand B.
- op  in  2  00 ADD a+b; 01 SUB a-b; 10 RSUB b-a; 11 NEG -b (a ignored).
- res  out  WIDTH  Result; registered.
- res_valid  out  1  High in DONE.
- res_ready  in  1  Consumer accepts result.
- cout  out  1  Carry out of MSB (SUB/RSUB/NEG: 1 = no borrow).
- ovf  out  1  Signed overflow = carry into MSB XOR carry out of MSB.
- zero  out  1  res == 0.
- neg  out  1  res[WIDTH-1].

Behaviour:
- Reset (rst=1 at an edge):
  - state goes to IDLE; res, cout, ovf, zero, neg and the digit counter are cleared; res_valid=0.
  - start_ready is decoded from state only, so it is 1 on the first cycle after reset.
  - Reset wins over every other event, including in RUN or DONE; an in-flight operation is discarded with no partial result.
- Operand conditioning at accept:
  - ADD: X=a, Y=b, cin=0.
  - SUB: X=a, Y=~b, cin=1.
  - RSUB: X=~a, Y=b, cin=1.
  - NEG: X=0, Y=~b, cin=1.
- IDLE: start_ready=1. On start_valid && start_ready:
  - latch X, Y and cin into shift registers; counter=0; go to RUN.
  - If start_valid is low, remain in IDLE.
- RUN (start_ready=0, res_valid=0):
  - Each cycle, sum the low DIGIT bits of X and Y with the carry register.
  - Shift the DIGIT-bit sum into the top of the res shift register; shift X and Y right by DIGIT.
  - Update the carry register; counter++.
  - On the digit with counter == N-1, also capture carry-into-MSB from inside that digit.
  - After the Nth digit, go to DONE:
    - cout = final carry; ovf = captured carry-into-MSB XOR cout; zero and neg are computed from the final res.
  - Inputs a, b, op and start_valid are ignored during RUN.
- Latency: accept edge at cycle k gives res_valid=1 from cycle k+N; exactly N RUN cycles.
- DONE: res_valid=1.
  - res and all flags hold stable until res_valid && res_ready; that edge returns to IDLE.
  - start_ready=0 throughout DONE; a new request is accepted no earlier than the cycle after the result handshake.
- Width rules:
  - The sum is WIDTH bits, modulo 2^WIDTH.
  - There is no extension.
  - The carry register is 1 bit.
  - The counter is clog2(N) bits, with a minimum of 1.
- Boundary cases:
  - NEG of 100..0 gives 100..0 with ovf=1.
  - NEG of 0 gives 0 with cout=1.
  - ADD with DIGIT=WIDTH completes in 1 RUN cycle.

Decomposition:
- Package addsub_pkg:
  - op enum (OP_ADD, OP_SUB, OP_RSUB, OP_NEG).
  - state enum (S_IDLE, S_RUN, S_DONE).
- Sub-module digit_adder:
  - Purely combinational DIGIT-bit adder.
  - Inputs: x, y, cin.
  - Outputs: sum, cout, c_msb (carry into its top bit).
- The top level holds the FSM, counter, shift registers and flag logic.

Test Plan:
- WIDTH=8, DIGIT=2, ADD a=0x7F b=0x01 -> res=0x80, cout=0, ovf=1, neg=1, zero=0; res_valid rises exactly 4 cycles after the accept edge.
- SUB a=0x00 b=0x00 -> res=0x00, cout=1, zero=1, ovf=0. SUB a=0x03 b=0x05 -> res=0xFE, cout=0, neg=1.
- RSUB a=0x05 b=0x03 -> res=0xFE, cout=0, neg=1. NEG b=0x80 -> res=0x80, ovf=1. NEG b=0x00 -> res=0x00, cout=1, zero=1.
- Backpressure: hold res_ready=0 for 10 cycles in DONE while toggling start_valid, a and b:
  - res and flags stay stable; start_ready=0; no accept.
  - Raise res_ready -> IDLE next cycle, start_ready=1.
- Reset mid-operation: assert rst after 2 RUN cycles of ADD 0x12+0x34:
  - next cycle IDLE, res=0x00, res_valid=0, flags 0.
  - A following ADD 0x12+0x34 yields 0x46 after 4 cycles.
- Parameter sweep DIGIT=8, WIDTH=8: ADD 0xFF+0x01 -> res=0x00, cout=1, zero=1, latency 1. Also WIDTH=16, DIGIT=4: SUB 0x8000-0x0001 -> 0x7FFF, ovf=1, latency 4.

Source files
------------

// File: rtl/addsub_pkg.sv
// ---------------------------------------------------------------------------
// addsub_pkg
// Shared types for the serial add/subtract unit.
//   op_e    : operation select carried on the 2-bit op port
//   state_e : control FSM states of serial_addsub
//   cnt_width() : width of the digit counter, never below 1 bit
// ---------------------------------------------------------------------------
package addsub_pkg;

   typedef enum logic [1:0] {
      OP_ADD  = 2'b00,   // a + b
      OP_SUB  = 2'b01,   // a - b
      OP_RSUB = 2'b10,   // b - a
      OP_NEG  = 2'b11    // -b, a ignored
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_e;

   // A single-digit operation still needs a 1-bit counter to exist.
   function automatic int cnt_width(input int n);
      if (n > 1) begin
         return $clog2(n);
      end else begin
         return 1;
      end
   endfunction

endpackage

// File: rtl/digit_adder.sv
// ---------------------------------------------------------------------------
// digit_adder
// Purely combinational DIGIT-bit ripple adder used once per cycle by the
// serial unit.
//   x, y  : DIGIT-bit addends
//   cin   : carry into bit 0
//   sum   : DIGIT-bit sum
//   cout  : carry out of the top bit
//   c_msb : carry into the top bit (needed for signed overflow)
// ---------------------------------------------------------------------------
module digit_adder #(
   parameter int DIGIT = 2
) (
   input  logic [DIGIT-1:0] x,
   input  logic [DIGIT-1:0] y,
   input  logic             cin,
   output logic [DIGIT-1:0] sum,
   output logic             cout,
   output logic             c_msb
);

   logic [DIGIT:0] w_c;

   // Ripple carry chain across the digit; w_c[i] is the carry into bit i.
   always_comb begin
      sum    = {DIGIT{1'b0}};
      w_c    = {(DIGIT+1){1'b0}};
      w_c[0] = cin;
      for (int i = 0; i < DIGIT; i++) begin
         sum[i]   = x[i] ^ y[i] ^ w_c[i];
         w_c[i+1] = (x[i] & y[i]) | (x[i] & w_c[i]) | (y[i] & w_c[i]);
      end
   end

   assign cout  = w_c[DIGIT];
   assign c_msb = w_c[DIGIT-1];

endmodule

// File: rtl/serial_addsub.sv
// ---------------------------------------------------------------------------
// serial_addsub
// Multi-cycle two's-complement add/subtract unit. Operands are conditioned
// (optional inversion plus carry-in) at accept time, then summed DIGIT bits
// per cycle over N = WIDTH/DIGIT cycles. Result and flags are held until the
// consumer takes them. WIDTH must be a multiple of DIGIT.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   start_valid/start_ready  : request handshake (ready only in IDLE)
//   a, b, op                 : operands and operation (see addsub_pkg::op_e)
//   res                      : registered WIDTH-bit result
//   res_valid/res_ready      : result handshake (valid only in DONE)
//   cout, ovf, zero, neg     : carry out, signed overflow, res==0, res sign
// ---------------------------------------------------------------------------
module serial_addsub
   import addsub_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       op,
   output logic [WIDTH-1:0] res,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             cout,
   output logic             ovf,
   output logic             zero,
   output logic             neg
);

   localparam int            N    = WIDTH / DIGIT;
   localparam int            CW   = cnt_width(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   state_e           r_state;
   state_e           w_state_nxt;

   logic [WIDTH-1:0] r_x;
   logic [WIDTH-1:0] r_y;
   logic [WIDTH-1:0] r_acc;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;

   logic [WIDTH-1:0] r_res;
   logic             r_cout;
   logic             r_ovf;
   logic             r_zero;
   logic             r_neg;

   logic [WIDTH-1:0] w_x_in;
   logic [WIDTH-1:0] w_y_in;
   logic             w_cin_in;

   logic [DIGIT-1:0]       w_sum;
   logic                   w_dcout;
   logic                   w_dcmsb;
   logic [WIDTH+DIGIT-1:0] w_acc_cat;
   logic [WIDTH-1:0]       w_acc_nxt;
   logic                   w_last;

   // Operand conditioning: subtraction is done as X + ~Y + 1.
   always_comb begin
      w_x_in   = a;
      w_y_in   = b;
      w_cin_in = 1'b0;
      case (op_e'(op))
         OP_ADD: begin
            w_x_in   = a;
            w_y_in   = b;
            w_cin_in = 1'b0;
         end
         OP_SUB: begin
            w_x_in   = a;
            w_y_in   = ~b;
            w_cin_in = 1'b1;
         end
         OP_RSUB: begin
            w_x_in   = ~a;
            w_y_in   = b;
            w_cin_in = 1'b1;
         end
         OP_NEG: begin
            w_x_in   = {WIDTH{1'b0}};
            w_y_in   = ~b;
            w_cin_in = 1'b1;
         end
         default: begin
            w_x_in   = a;
            w_y_in   = b;
            w_cin_in = 1'b0;
         end
      endcase
   end

   digit_adder #(
      .DIGIT (DIGIT)
   ) u_digit (
      .x     (r_x[DIGIT-1:0]),
      .y     (r_y[DIGIT-1:0]),
      .cin   (r_carry),
      .sum   (w_sum),
      .cout  (w_dcout),
      .c_msb (w_dcmsb)
   );

   // The new digit enters at the top; concatenating first keeps the slice
   // legal even when DIGIT equals WIDTH.
   assign w_acc_cat = {w_sum, r_acc};
   assign w_acc_nxt = w_acc_cat[WIDTH+DIGIT-1:DIGIT];
   assign w_last    = (r_cnt == LAST);

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next-state decode.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (start_valid) begin
               w_state_nxt = S_RUN;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_RUN: begin
            if (w_last) begin
               w_state_nxt = S_DONE;
            end else begin
               w_state_nxt = S_RUN;
            end
         end
         S_DONE: begin
            if (res_ready) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_DONE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Datapath: operand load, per-digit shift/accumulate, result and flag capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_x     <= {WIDTH{1'b0}};
         r_y     <= {WIDTH{1'b0}};
         r_acc   <= {WIDTH{1'b0}};
         r_carry <= 1'b0;
         r_cnt   <= {CW{1'b0}};
         r_res   <= {WIDTH{1'b0}};
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
         r_zero  <= 1'b0;
         r_neg   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start_valid) begin
                  r_x     <= w_x_in;
                  r_y     <= w_y_in;
                  r_carry <= w_cin_in;
                  r_cnt   <= {CW{1'b0}};
               end
            end
            S_RUN: begin
               r_x     <= r_x >> DIGIT;
               r_y     <= r_y >> DIGIT;
               r_acc   <= w_acc_nxt;
               r_carry <= w_dcout;
               r_cnt   <= r_cnt + CW'(1);
               // On the top digit the adder's internal carry is the carry
               // into the MSB, so overflow is available this same cycle.
               if (w_last) begin
                  r_res  <= w_acc_nxt;
                  r_cout <= w_dcout;
                  r_ovf  <= w_dcmsb ^ w_dcout;
                  r_zero <= (w_acc_nxt == {WIDTH{1'b0}});
                  r_neg  <= w_acc_nxt[WIDTH-1];
               end
            end
            default: begin
               r_x <= r_x;
            end
         endcase
      end
   end

   assign start_ready = (r_state == S_IDLE);
   assign res_valid   = (r_state == S_DONE);
   assign res         = r_res;
   assign cout        = r_cout;
   assign ovf         = r_ovf;
   assign zero        = r_zero;
   assign neg         = r_neg;

endmodule

// File: tb/tb_serial_addsub.sv
// ---------------------------------------------------------------------------
// tb_serial_addsub
// Scoreboard bench for serial_addsub. Three instances: 8/2, 8/8 and 16/4.
// The driver pushes hand-computed expectations into a per-instance queue; a
// monitor pops and compares whenever a result handshake is presented.
// ---------------------------------------------------------------------------
module tb_serial_addsub;

   typedef struct {
      logic [15:0] res;
      logic        cout;
      logic        ovf;
      logic        zero;
      logic        neg;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        sv   [3];
   logic        srdy [3];
   logic [15:0] ta   [3];
   logic [15:0] tb   [3];
   logic [1:0]  top  [3];
   logic        rv   [3];
   logic        rr   [3];
   logic        co   [3];
   logic        ov   [3];
   logic        zr   [3];
   logic        ng   [3];
   logic [7:0]  res0;
   logic [7:0]  res1;
   logic [15:0] res2;

   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];

   int n_tests = 0;
   int n_fail  = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   serial_addsub #(.WIDTH(8), .DIGIT(2)) u_d0 (
      .clk(clk), .rst(rst), .start_valid(sv[0]), .start_ready(srdy[0]),
      .a(ta[0][7:0]), .b(tb[0][7:0]), .op(top[0]), .res(res0),
      .res_valid(rv[0]), .res_ready(rr[0]), .cout(co[0]), .ovf(ov[0]),
      .zero(zr[0]), .neg(ng[0]));

   serial_addsub #(.WIDTH(8), .DIGIT(8)) u_d1 (
      .clk(clk), .rst(rst), .start_valid(sv[1]), .start_ready(srdy[1]),
      .a(ta[1][7:0]), .b(tb[1][7:0]), .op(top[1]), .res(res1),
      .res_valid(rv[1]), .res_ready(rr[1]), .cout(co[1]), .ovf(ov[1]),
      .zero(zr[1]), .neg(ng[1]));

   serial_addsub #(.WIDTH(16), .DIGIT(4)) u_d2 (
      .clk(clk), .rst(rst), .start_valid(sv[2]), .start_ready(srdy[2]),
      .a(ta[2]), .b(tb[2]), .op(top[2]), .res(res2),
      .res_valid(rv[2]), .res_ready(rr[2]), .cout(co[2]), .ovf(ov[2]),
      .zero(zr[2]), .neg(ng[2]));

   function automatic logic [15:0] get_res(input int d);
      case (d)
         0:       return {8'h00, res0};
         1:       return {8'h00, res1};
         default: return res2;
      endcase
   endfunction

   task automatic chk(input int d, input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL dut%0d %s: got %0h, expected %0h", d, name, act, exp);
      end
   endtask

   task automatic check_res(input int d, input exp_t e);
      chk(d, "res",  32'(get_res(d)), 32'(e.res));
      chk(d, "cout", 32'(co[d]), 32'(e.cout));
      chk(d, "ovf",  32'(ov[d]), 32'(e.ovf));
      chk(d, "zero", 32'(zr[d]), 32'(e.zero));
      chk(d, "neg",  32'(ng[d]), 32'(e.neg));
   endtask

   // Monitor: compare on every presented result handshake.
   always @(negedge clk) begin
      if (rv[0] && rr[0]) begin
         if (q0.size() == 0) chk(0, "unexpected_result", 32'd1, 32'd0);
         else                check_res(0, q0.pop_front());
      end
      if (rv[1] && rr[1]) begin
         if (q1.size() == 0) chk(1, "unexpected_result", 32'd1, 32'd0);
         else                check_res(1, q1.pop_front());
      end
      if (rv[2] && rr[2]) begin
         if (q2.size() == 0) chk(2, "unexpected_result", 32'd1, 32'd0);
         else                check_res(2, q2.pop_front());
      end
   end

   // Issue one operation; entered and left at posedge+#1. hold>0 keeps
   // res_ready low for that many DONE cycles while disturbing the inputs.
   task automatic run_op(input int d, input logic [1:0] op, input logic [15:0] a,
                         input logic [15:0] b, input exp_t e, input int exp_lat,
                         input int hold);
      int n;
      int lat;
      n = 0;
      while (!srdy[d] && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!srdy[d]) begin
         chk(d, "start_ready_timeout", 32'd0, 32'd1);
         return;
      end
      ta[d]  = a;
      tb[d]  = b;
      top[d] = op;
      sv[d]  = 1'b1;
      rr[d]  = (hold == 0);
      case (d)
         0:       q0.push_back(e);
         1:       q1.push_back(e);
         default: q2.push_back(e);
      endcase
      @(posedge clk); #1;
      sv[d] = 1'b0;
      lat = 0;
      while (!rv[d] && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      chk(d, "latency", 32'(lat), 32'(exp_lat));
      for (int i = 0; i < hold; i++) begin
         sv[d] = 1'($urandom_range(0, 1));
         ta[d] = 16'($urandom);
         tb[d] = 16'($urandom);
         @(negedge clk);
         chk(d, "hold_res",   32'(get_res(d)), 32'(e.res));
         chk(d, "hold_flags", {28'd0, co[d], ov[d], zr[d], ng[d]},
             {28'd0, e.cout, e.ovf, e.zero, e.neg});
         chk(d, "hold_start_ready", 32'(srdy[d]), 32'd0);
         chk(d, "hold_res_valid",   32'(rv[d]), 32'd1);
         @(posedge clk); #1;
      end
      sv[d] = 1'b0;
      rr[d] = 1'b1;
      @(posedge clk); #1;
      chk(d, "idle_start_ready", 32'(srdy[d]), 32'd1);
      chk(d, "idle_res_valid",   32'(rv[d]), 32'd0);
   endtask

   function automatic exp_t mk(input logic [15:0] r, input logic c, input logic o,
                               input logic z, input logic n);
      exp_t e;
      e.res = r; e.cout = c; e.ovf = o; e.zero = z; e.neg = n;
      return e;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      for (int d = 0; d < 3; d++) begin
         sv[d] = 1'b0; rr[d] = 1'b1; ta[d] = 16'h0000; tb[d] = 16'h0000; top[d] = 2'b00;
      end
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      for (int d = 0; d < 3; d++) begin
         chk(d, "rst_start_ready", 32'(srdy[d]), 32'd1);
         chk(d, "rst_res_valid",   32'(rv[d]), 32'd0);
         chk(d, "rst_res",         32'(get_res(d)), 32'd0);
         chk(d, "rst_flags", {28'd0, co[d], ov[d], zr[d], ng[d]}, 32'd0);
      end

      // 8-bit, 2 bits per cycle
      run_op(0, 2'b00, 16'h007F, 16'h0001, mk(16'h0080, 1'b0, 1'b1, 1'b0, 1'b1), 4, 0);
      run_op(0, 2'b01, 16'h0000, 16'h0000, mk(16'h0000, 1'b1, 1'b0, 1'b1, 1'b0), 4, 0);
      run_op(0, 2'b01, 16'h0003, 16'h0005, mk(16'h00FE, 1'b0, 1'b0, 1'b0, 1'b1), 4, 0);
      run_op(0, 2'b10, 16'h0005, 16'h0003, mk(16'h00FE, 1'b0, 1'b0, 1'b0, 1'b1), 4, 0);
      run_op(0, 2'b11, 16'h0055, 16'h0080, mk(16'h0080, 1'b0, 1'b1, 1'b0, 1'b1), 4, 0);
      run_op(0, 2'b11, 16'h00AA, 16'h0000, mk(16'h0000, 1'b1, 1'b0, 1'b1, 1'b0), 4, 0);
      // backpressure: 0x40 + 0x40 held for 10 cycles
      run_op(0, 2'b00, 16'h0040, 16'h0040, mk(16'h0080, 1'b0, 1'b1, 1'b0, 1'b1), 4, 10);

      // reset two RUN cycles into ADD 0x12 + 0x34
      ta[0] = 16'h0012; tb[0] = 16'h0034; top[0] = 2'b00; sv[0] = 1'b1;
      @(posedge clk); #1;
      sv[0] = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk(0, "abort_start_ready", 32'(srdy[0]), 32'd1);
      chk(0, "abort_res_valid",   32'(rv[0]), 32'd0);
      chk(0, "abort_res",         32'(res0), 32'd0);
      chk(0, "abort_flags", {28'd0, co[0], ov[0], zr[0], ng[0]}, 32'd0);
      run_op(0, 2'b00, 16'h0012, 16'h0034, mk(16'h0046, 1'b0, 1'b0, 1'b0, 1'b0), 4, 0);

      // 8-bit, single digit
      run_op(1, 2'b00, 16'h00FF, 16'h0001, mk(16'h0000, 1'b1, 1'b0, 1'b1, 1'b0), 1, 0);
      run_op(1, 2'b01, 16'h0080, 16'h0001, mk(16'h007F, 1'b1, 1'b1, 1'b0, 1'b0), 1, 0);

      // 16-bit, 4 bits per cycle
      run_op(2, 2'b01, 16'h8000, 16'h0001, mk(16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0), 4, 0);
      run_op(2, 2'b00, 16'h1234, 16'h4321, mk(16'h5555, 1'b0, 1'b0, 1'b0, 1'b0), 4, 0);

      @(posedge clk); #1;
      chk(0, "queue_left", 32'(q0.size()), 32'd0);
      chk(1, "queue_left", 32'(q1.size()), 32'd0);
      chk(2, "queue_left", 32'(q2.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
